// File: rtl/sequence_checker_pkg.sv
// Shared definitions for the sequence checker: FSM states,
// selection codes and the one-cold code test.
package sequence_checker_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_COMPARE = 3'd2,
        S_PASS    = 3'd3,
        S_FAIL    = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    localparam logic [3:0] CODE_0 = 4'b1110;
    localparam logic [3:0] CODE_1 = 4'b1101;
    localparam logic [3:0] CODE_2 = 4'b1011;
    localparam logic [3:0] CODE_3 = 4'b0111;

    function automatic logic is_one_cold(input logic [3:0] code);
        return (code == CODE_0) || (code == CODE_1) ||
               (code == CODE_2) || (code == CODE_3);
    endfunction

endpackage

// File: rtl/sequence_checker_attempt_timer.sv
// Per-attempt second counter; expire holds once the count
// reaches TIMEOUT_SEC and stays there until cleared.
module sequence_checker_attempt_timer #(
    parameter int TIMEOUT_SEC = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_SEC);

    logic [7:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && !expire) begin
            count <= count + 8'd1;
        end
    end

    assign expire = (count == LIMIT);

endmodule

// File: rtl/sequence_checker.sv
// Captures four confirmed selection codes per attempt and
// compares them with the target; tracks strikes and lockout.
module sequence_checker
    import sequence_checker_pkg::*;
#(
    parameter int MAX_STRIKES = 3,
    parameter int TIMEOUT_SEC = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        one_sec,
    input  logic        button_next,
    input  logic [3:0]  sel_code,
    input  logic [15:0] target_seq,
    output logic [1:0]  slot_idx,
    output logic        busy,
    output logic        defused,
    output logic        strike_pulse,
    output logic        timed_out,
    output logic [1:0]  strikes,
    output logic        exploded
);

    localparam logic [1:0] MAX_S = 2'(MAX_STRIKES);

    state_t      state;
    logic [15:0] captured;
    logic        expire;
    logic        timer_clear;
    logic        timer_tick;
    logic        match;
    logic [1:0]  strikes_inc;
    logic        lock_now;
    state_t      fail_state;

    assign timer_tick  = one_sec && (state == S_COLLECT);
    assign timer_clear = start && (state != S_LOCKOUT) &&
                         (state != S_COMPARE);

    sequence_checker_attempt_timer #(
        .TIMEOUT_SEC(TIMEOUT_SEC)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear),
        .tick  (timer_tick),
        .expire(expire)
    );

    // An invalid nibble fails even if the target holds the same value.
    always_comb begin
        match = (captured == target_seq);
        for (int k = 0; k < 4; k++) begin
            if (!is_one_cold(captured[4*k +: 4])) match = 1'b0;
        end
    end

    assign strikes_inc = strikes + 2'd1;
    assign lock_now    = (strikes_inc == MAX_S);
    assign fail_state  = lock_now ? S_LOCKOUT : S_FAIL;
    assign busy        = (state == S_COLLECT) || (state == S_COMPARE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            captured     <= '0;
            slot_idx     <= '0;
            defused      <= 1'b0;
            strike_pulse <= 1'b0;
            timed_out    <= 1'b0;
            strikes      <= '0;
            exploded     <= 1'b0;
        end else begin
            strike_pulse <= 1'b0;
            unique case (state)
                S_IDLE, S_PASS, S_FAIL: begin
                    if (start) begin
                        captured  <= '0;
                        slot_idx  <= '0;
                        defused   <= 1'b0;
                        timed_out <= 1'b0;
                        state     <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (start) begin
                        captured <= '0;
                        slot_idx <= '0;
                    end else if (button_next) begin
                        captured[{slot_idx, 2'b00} +: 4] <= sel_code;
                        slot_idx <= slot_idx + 2'd1;
                        if (slot_idx == 2'd3) state <= S_COMPARE;
                    end else if (expire) begin
                        timed_out    <= 1'b1;
                        strike_pulse <= 1'b1;
                        strikes      <= strikes_inc;
                        exploded     <= lock_now;
                        state        <= fail_state;
                    end
                end
                S_COMPARE: begin
                    if (match) begin
                        defused <= 1'b1;
                        state   <= S_PASS;
                    end else begin
                        strike_pulse <= 1'b1;
                        strikes      <= strikes_inc;
                        exploded     <= lock_now;
                        state        <= fail_state;
                    end
                end
                S_LOCKOUT: begin
                    exploded <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_checker.sv
// Bench for sequence_checker: directed table, corner sequences
// and randomized traffic against an attempt-level model.
module tb_sequence_checker;

    localparam int MAX_STRIKES = 3;
    localparam int TIMEOUT_SEC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        one_sec = 1'b0;
    logic        button_next = 1'b0;
    logic [3:0]  sel_code = 4'hF;
    logic [15:0] target_seq = 16'h7BDE;
    logic [1:0]  slot_idx;
    logic        busy;
    logic        defused;
    logic        strike_pulse;
    logic        timed_out;
    logic [1:0]  strikes;
    logic        exploded;

    int n_pass = 0;
    int n_total = 0;

    sequence_checker #(
        .MAX_STRIKES(MAX_STRIKES),
        .TIMEOUT_SEC(TIMEOUT_SEC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .one_sec     (one_sec),
        .button_next (button_next),
        .sel_code    (sel_code),
        .target_seq  (target_seq),
        .slot_idx    (slot_idx),
        .busy        (busy),
        .defused     (defused),
        .strike_pulse(strike_pulse),
        .timed_out   (timed_out),
        .strikes     (strikes),
        .exploded    (exploded)
    );

    always #5 clk = ~clk;

    // Packed view: {slot, busy, defused, pulse, timed_out, strikes, exploded}
    function automatic logic [8:0] dut_out();
        return {slot_idx, busy, defused, strike_pulse,
                timed_out, strikes, exploded};
    endfunction

    task automatic check(input string name, input logic [8:0] act,
                         input logic [8:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Attempt-level reference model
    bit         m_active, m_cmp, m_def, m_to, m_exp, m_pulse;
    int         m_secs, m_strikes;
    logic [3:0] m_ent[$];

    function automatic void model_reset();
        m_active = 0; m_cmp = 0; m_def = 0; m_to = 0;
        m_exp = 0; m_pulse = 0; m_secs = 0; m_strikes = 0;
        m_ent.delete();
    endfunction

    function automatic bit model_match(input logic [15:0] tgt);
        if (m_ent.size() != 4) return 0;
        for (int k = 0; k < 4; k++) begin
            if (m_ent[k] !== tgt[4*k +: 4]) return 0;
            if ($countones(~m_ent[k]) != 1) return 0;
        end
        return 1;
    endfunction

    function automatic void model_fail(input bit by_time);
        m_to = by_time;
        m_strikes++;
        m_pulse = 1;
        if (m_strikes == MAX_STRIKES) m_exp = 1;
    endfunction

    function automatic void model_step(input bit s, input bit n,
                                       input bit t,
                                       input logic [3:0] code);
        m_pulse = 0;
        if (m_exp) return;
        if (m_cmp) begin
            m_cmp = 0;
            m_active = 0;
            if (model_match(target_seq)) m_def = 1;
            else model_fail(0);
        end else if (m_active) begin
            if (s) begin
                m_ent.delete();
            end else if (n) begin
                m_ent.push_back(code);
                if (m_ent.size() == 4) m_cmp = 1;
            end else if (m_secs >= TIMEOUT_SEC) begin
                m_active = 0;
                model_fail(1);
            end
            if (s) m_secs = 0;
            else if (t && m_secs < TIMEOUT_SEC) m_secs++;
        end else if (s) begin
            m_active = 1;
            m_ent.delete();
            m_secs = 0;
            m_def = 0;
            m_to = 0;
        end
    endfunction

    function automatic logic [8:0] model_out();
        logic [1:0] sl;
        logic [1:0] st;
        sl = 2'(m_ent.size() % 4);
        st = 2'(m_strikes);
        return {sl, m_active, m_def, m_pulse, m_to, st, m_exp};
    endfunction

    task automatic cycle(input bit s, input bit n, input bit t,
                         input logic [3:0] code);
        start = s;
        button_next = n;
        one_sec = t;
        sel_code = code;
        @(posedge clk);
        model_step(s, n, t, code);
        #1;
        start = 0;
        button_next = 0;
        one_sec = 0;
    endtask

    task automatic async_reset(input string name);
        #2 reset = 1'b1;
        #1 check(name, dut_out(), 9'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        bit         s, n, t;
        logic [3:0] sel;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [3:0] codes[4];
        logic [3:0] pick;
        int k;
        codes[0] = 4'hE; codes[1] = 4'hD;
        codes[2] = 4'hB; codes[3] = 4'h7;

        // {s,n,t,sel, {slot,busy,def,pulse,to,strikes,exp}}
        tbl[0]  = '{1, 0, 0, 4'hF, 9'b00_1_0_0_0_00_0};
        tbl[1]  = '{0, 1, 0, 4'hE, 9'b01_1_0_0_0_00_0};
        tbl[2]  = '{0, 1, 0, 4'hD, 9'b10_1_0_0_0_00_0};
        tbl[3]  = '{0, 1, 0, 4'hB, 9'b11_1_0_0_0_00_0};
        tbl[4]  = '{0, 1, 0, 4'h7, 9'b00_1_0_0_0_00_0};
        tbl[5]  = '{0, 0, 0, 4'hF, 9'b00_0_1_0_0_00_0};
        tbl[6]  = '{0, 1, 1, 4'hE, 9'b00_0_1_0_0_00_0};
        tbl[7]  = '{1, 0, 0, 4'hF, 9'b00_1_0_0_0_00_0};
        tbl[8]  = '{0, 1, 0, 4'hE, 9'b01_1_0_0_0_00_0};
        tbl[9]  = '{0, 1, 0, 4'hE, 9'b10_1_0_0_0_00_0};
        tbl[10] = '{0, 1, 0, 4'hB, 9'b11_1_0_0_0_00_0};
        tbl[11] = '{0, 1, 0, 4'h7, 9'b00_1_0_0_0_00_0};
        tbl[12] = '{0, 0, 0, 4'hF, 9'b00_0_0_1_0_01_0};
        tbl[13] = '{0, 0, 0, 4'hF, 9'b00_0_0_0_0_01_0};

        model_reset();
        #1 check("reset_state", dut_out(), 9'd0);
        @(negedge clk);
        reset = 1'b0;

        target_seq = 16'h7BDE;
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].s, tbl[i].n, tbl[i].t, tbl[i].sel);
            check($sformatf("table[%0d]", i), dut_out(), tbl[i].exp);
        end

        // Invalid code matching an invalid target nibble still fails
        target_seq = 16'h7BDC;
        cycle(1, 0, 0, 4'hF);
        cycle(0, 1, 0, 4'hC);
        cycle(0, 1, 0, 4'hD);
        cycle(0, 1, 0, 4'hB);
        cycle(0, 1, 0, 4'h7);
        cycle(0, 0, 0, 4'hF);
        check("invalid_fail", dut_out(), 9'b00_0_0_1_0_10_0);

        // Third failure explodes; lockout ignores everything
        cycle(1, 0, 0, 4'hF);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 4'hE);
        check("third_compare", dut_out(), 9'b00_1_0_0_0_10_0);
        cycle(0, 0, 0, 4'hF);
        check("explode", dut_out(), 9'b00_0_0_1_0_11_1);
        cycle(1, 0, 0, 4'hF);
        check("lock_start", dut_out(), 9'b00_0_0_0_0_11_1);
        cycle(0, 1, 1, 4'hE);
        cycle(1, 0, 1, 4'hE);
        check("lock_hold", dut_out(), 9'b00_0_0_0_0_11_1);
        async_reset("reset_lockout");

        // Timeout after two ticks with no entries
        target_seq = 16'h7BDE;
        cycle(1, 0, 0, 4'hF);
        cycle(0, 0, 1, 4'hF);
        cycle(0, 0, 1, 4'hF);
        check("tick2", dut_out(), 9'b00_1_0_0_0_00_0);
        cycle(0, 0, 0, 4'hF);
        check("timeout", dut_out(), 9'b00_0_0_1_1_01_0);

        // Fourth entry together with the final tick wins
        cycle(1, 0, 0, 4'hF);
        check("restart_to", dut_out(), 9'b00_1_0_0_0_01_0);
        cycle(0, 1, 1, 4'hE);
        cycle(0, 1, 0, 4'hD);
        cycle(0, 1, 0, 4'hB);
        cycle(0, 1, 1, 4'h7);
        check("race_compare", dut_out(), 9'b00_1_0_0_0_01_0);
        cycle(0, 0, 0, 4'hF);
        check("race_pass", dut_out(), 9'b00_0_1_0_0_01_0);

        // Async reset mid-collect, then a clean start at slot 0
        cycle(1, 0, 0, 4'hF);
        cycle(0, 1, 0, 4'hE);
        cycle(0, 1, 0, 4'hD);
        check("mid_collect", dut_out(), 9'b10_1_0_0_0_01_0);
        async_reset("reset_collect");
        cycle(1, 0, 0, 4'hF);
        check("post_reset", dut_out(), 9'b00_1_0_0_0_00_0);
        cycle(0, 1, 0, 4'hE);
        check("post_reset_e", dut_out(), 9'b01_1_0_0_0_00_0);

        // Randomized traffic against the model
        async_reset("reset_rand");
        for (int i = 0; i < 3000; i++) begin
            bit s, n, t;
            s = ($urandom_range(0, 99) < 4);
            n = ($urandom_range(0, 99) < 30);
            t = ($urandom_range(0, 99) < 6);
            if (s) begin
                target_seq = '0;
                for (int j = 0; j < 4; j++)
                    target_seq[4*j +: 4] = codes[$urandom_range(0, 3)];
                if ($urandom_range(0, 7) == 0)
                    target_seq[4*$urandom_range(0, 3) +: 4] =
                        4'($urandom);
            end
            k = $urandom_range(0, 9);
            if (k < 7) pick = target_seq[4*(m_ent.size() % 4) +: 4];
            else if (k < 9) pick = codes[$urandom_range(0, 3)];
            else pick = 4'($urandom);
            cycle(s, n, t, pick);
            check($sformatf("rand[%0d]", i), dut_out(), model_out());
            if ((m_exp && $urandom_range(0, 5) == 0) ||
                $urandom_range(0, 499) == 0)
                async_reset($sformatf("rand_reset[%0d]", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
